// File: rtl/tea_decrypt_accel.sv
// Iterative TEA block decryptor with AXI-Stream-style in/out handshakes; one round per clock.
// Optional macro TEA_DEC_UNROLL2_EN chains two rounds per cycle (NUM_ROUNDS must then be even).
module tea_decrypt_accel #(
  parameter int          NUM_ROUNDS = 32,
  parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_key,
  input  logic         i_axis_valid_s,
  output logic         o_axis_ready_s,
  input  logic [63:0]  i_axis_data_s,
  output logic         o_axis_valid_m,
  input  logic         i_axis_ready_m,
  output logic [63:0]  o_axis_data_m
);
  localparam logic [31:0] SUM_INIT = DELTA * 32'(NUM_ROUNDS);
  localparam int          CW       = $clog2(NUM_ROUNDS) + 1;
`ifdef TEA_DEC_UNROLL2_EN
  localparam logic [CW-1:0] STEP = CW'(2);
`else
  localparam logic [CW-1:0] STEP = CW'(1);
`endif
  localparam logic [CW-1:0] LAST = CW'(NUM_ROUNDS) - STEP;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [63:0]     v, v_nx, rnd, data_nx;
  logic [31:0]     sum, sum_nx, sum_step;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [127:0]    key, key_nx;
  logic            ready_nx, valid_nx;

  // One inverse TEA round: undo v1 first using the old v0, then v0 using the new v1.
  function automatic logic [63:0] dec_round(input logic [63:0] vin, input logic [31:0] s,
                                            input logic [127:0] k);
    logic [31:0] v0, v1;
    v0 = vin[31:0];
    v1 = vin[63:32];
    v1 = v1 - (((v0 << 4) + k[95:64]) ^ (v0 + s) ^ ((v0 >> 5) + k[127:96]));
    v0 = v0 - (((v1 << 4) + k[31:0])  ^ (v1 + s) ^ ((v1 >> 5) + k[63:32]));
    return {v1, v0};
  endfunction

`ifdef TEA_DEC_UNROLL2_EN
  assign rnd      = dec_round(dec_round(v, sum, key), sum - DELTA, key);
  assign sum_step = sum - (DELTA << 1);
`else
  assign rnd      = dec_round(v, sum, key);
  assign sum_step = sum - DELTA;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    v_nx     = v;
    sum_nx   = sum;
    cnt_nx   = cnt;
    key_nx   = key;
    valid_nx = o_axis_valid_m;
    data_nx  = o_axis_data_m;
    case (state)
      IDLE: if (i_axis_valid_s && o_axis_ready_s) begin
        v_nx     = i_axis_data_s;
        key_nx   = i_key;
        sum_nx   = SUM_INIT;
        cnt_nx   = '0;
        state_nx = RUN;
      end
      RUN: begin
        v_nx   = rnd;
        sum_nx = sum_step;
        cnt_nx = cnt + STEP;
        if (cnt == LAST) begin
          data_nx  = rnd;
          valid_nx = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: if (o_axis_valid_m && i_axis_ready_m) begin
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // ready is registered; it follows the state we are about to enter
    ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v              <= '0;
      sum            <= '0;
      cnt            <= '0;
      key            <= '0;
      o_axis_ready_s <= 1'b0;
      o_axis_valid_m <= 1'b0;
      o_axis_data_m  <= '0;
    end else begin
      v              <= v_nx;
      sum            <= sum_nx;
      cnt            <= cnt_nx;
      key            <= key_nx;
      o_axis_ready_s <= ready_nx;
      o_axis_valid_m <= valid_nx;
      o_axis_data_m  <= data_nx;
    end
  end
endmodule
